// File: rtl/i2c_config_sequencer_pkg.sv
// Shared types for the I2C configuration sequencer: FSM states, table entry
// layout and the 27-bit regdata formatter used by I2C_write.
package i2c_config_sequencer_pkg;

    localparam int unsigned ENTRY_W   = 24;
    localparam int unsigned REGDATA_W = 27;

    // Released SDA slot following each byte so the slave can drive ACK
    localparam logic ACK_SLOT = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_GO,
        ST_WAIT,
        ST_CHECK,
        ST_GAP,
        ST_FINISH,
        ST_FAIL
    } state_e;

    typedef struct packed {
        logic [7:0] dev;
        logic [7:0] reg_addr;
        logic [7:0] dat;
    } entry_t;

    function automatic logic [REGDATA_W-1:0] format_word(input entry_t e);
        return {e.dev, ACK_SLOT, e.reg_addr, ACK_SLOT, e.dat, ACK_SLOT};
    endfunction

endpackage

// File: rtl/i2c_config_rom.sv
// Codec bring-up table: {device, register, data} per index; indices at or
// beyond NUM_REGS read as zero.
module i2c_config_rom
    import i2c_config_sequencer_pkg::*;
#(
    parameter int unsigned IDX_W    = 4,
    parameter int unsigned NUM_REGS = 10
) (
    input  logic [IDX_W-1:0]   idx_i,
    output logic [ENTRY_W-1:0] entry_o
);

    logic [ENTRY_W-1:0] table_c;

    always_comb begin
        table_c = '0;
        case (idx_i)
            IDX_W'(0): table_c = 24'h34_1E_00;
            IDX_W'(1): table_c = 24'h34_00_17;
            IDX_W'(2): table_c = 24'h34_02_17;
            IDX_W'(3): table_c = 24'h34_04_79;
            IDX_W'(4): table_c = 24'h34_06_79;
            IDX_W'(5): table_c = 24'h34_08_12;
            IDX_W'(6): table_c = 24'h34_0A_06;
            IDX_W'(7): table_c = 24'h34_0C_00;
            IDX_W'(8): table_c = 24'h34_0E_42;
            IDX_W'(9): table_c = 24'h34_12_01;
            default:   table_c = '0;
        endcase
        entry_o = (32'(idx_i) < NUM_REGS) ? table_c : '0;
    end

endmodule

// File: rtl/i2c_config_sequencer.sv
// Walks the configuration table and issues one I2C_write transfer per entry,
// retrying on NACK or timeout and spacing transfers with an idle gap.
module i2c_config_sequencer
    import i2c_config_sequencer_pkg::*;
#(
    parameter int unsigned NUM_REGS       = 10,
    parameter int unsigned IDX_W          = 4,
    parameter int unsigned MAX_RETRY      = 3,
    parameter int unsigned GAP_CYCLES     = 250,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic                 CLK,
    input  logic                 reset,
    input  logic                 start,
    output logic [REGDATA_W-1:0] i2c_regdata,
    output logic                 i2c_go,
    input  logic                 i2c_done,
    input  logic                 i2c_nack,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [IDX_W-1:0]     index
);

    localparam int unsigned RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int unsigned CNT_MAX = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    state_e                 state_q,   state_d;
    logic [IDX_W-1:0]       index_q,   index_d;
    logic [RETRY_W-1:0]     retry_q,   retry_d;
    logic [CNT_W-1:0]       cnt_q,     cnt_d;
    logic                   nack_q,    nack_d;
    logic [REGDATA_W-1:0]   regdata_q, regdata_d;
    logic                   go_q,      go_d;
    logic                   busy_q,    busy_d;
    logic                   done_q,    done_d;
    logic                   error_q,   error_d;
    logic [ENTRY_W-1:0]     rom_entry;

    i2c_config_rom #(
        .IDX_W    (IDX_W),
        .NUM_REGS (NUM_REGS)
    ) u_rom (
        .idx_i   (index_q),
        .entry_o (rom_entry)
    );

    // One shared counter: timeout while in WAIT, idle spacing while in GAP
    always_comb begin
        state_d   = state_q;
        index_d   = index_q;
        retry_d   = retry_q;
        cnt_d     = cnt_q;
        nack_d    = nack_q;
        regdata_d = regdata_q;
        go_d      = 1'b0;
        busy_d    = busy_q;
        done_d    = done_q;
        error_d   = error_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    done_d  = 1'b0;
                    error_d = 1'b0;
                    busy_d  = 1'b1;
                    index_d = '0;
                    retry_d = '0;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                regdata_d = format_word(entry_t'(rom_entry));
                go_d      = 1'b1;
                state_d   = ST_GO;
            end
            ST_GO: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (i2c_done) begin
                    nack_d  = i2c_nack;
                    state_d = ST_CHECK;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    nack_d  = 1'b1;
                    state_d = ST_CHECK;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_CHECK: begin
                cnt_d = '0;
                if (!nack_q) begin
                    if (index_q == IDX_W'(NUM_REGS - 1)) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = ST_FINISH;
                    end else begin
                        index_d = index_q + IDX_W'(1);
                        retry_d = '0;
                        state_d = ST_GAP;
                    end
                end else if (retry_q < RETRY_W'(MAX_RETRY)) begin
                    retry_d = retry_q + RETRY_W'(1);
                    state_d = ST_GAP;
                end else begin
                    busy_d  = 1'b0;
                    error_d = 1'b1;
                    state_d = ST_FAIL;
                end
            end
            ST_GAP: begin
                if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
                    state_d = ST_LOAD;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_FINISH: state_d = ST_IDLE;
            ST_FAIL:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            index_q   <= '0;
            retry_q   <= '0;
            cnt_q     <= '0;
            nack_q    <= 1'b0;
            regdata_q <= '0;
            go_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            index_q   <= index_d;
            retry_q   <= retry_d;
            cnt_q     <= cnt_d;
            nack_q    <= nack_d;
            regdata_q <= regdata_d;
            go_q      <= go_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            error_q   <= error_d;
        end
    end

    assign i2c_regdata = regdata_q;
    assign i2c_go      = go_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign error       = error_q;
    assign index       = index_q;

endmodule
